// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arb4_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             any_req;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, any_req, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, any_req, timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority search: first asserted request at or after ptr, wrapping 3 -> 0.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  // NOTE: outputs get defaults before the loop so every path assigns them and no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    // Walk from the farthest offset down so the nearest hit is the one that sticks.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[ptr + ID_W'(i)]) begin
        valid = 1'b1;
        idx   = ptr + ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a per-grant hold limit and forced release.
module rr_arb4
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input logic        clk,
  input logic        rst_n,
  rr_arb4_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [N_REQ-1:0]   gnt_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic               busy_q;
  logic               timeout_q;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_idx;
  logic               owner_req;

  rr_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_req = bus.req[gnt_id_q];

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state)
        IDLE, RELEASE: begin
          if (pick_valid) begin
            state    <= GRANT;
            gnt_q    <= onehot(pick_idx);
            gnt_id_q <= pick_idx;
            busy_q   <= 1'b1;
            hold_cnt <= CNT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (bus.done || !owner_req || hold_cnt == HOLD_LIM) begin
            state     <= RELEASE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            ptr       <= gnt_id_q + ID_W'(1);
            // Forced release only when the limit was the sole reason to leave.
            timeout_q <= !bus.done && owner_req;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
  assign bus.any_req = |bus.req;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed vectors, a per-cycle reference model and a random soak.
module tb_rr_arb4;
  import rr_arb_pkg::*;

  localparam int HOLD_MAX = 8;
  localparam int BOUND    = 3 * (HOLD_MAX + 1);

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_arb4_if bus ();

  rr_arb4 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge and stay stable across the next one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: who owns the resource, for how long, and where the search starts next.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_last  = -1;
  bit m_to    = 1'b0;
  bit m_rel   = 1'b0;
  int age [N_REQ];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_to    = 1'b0;
      m_rel   = 1'b0;
    end else if (m_owner >= 0) begin
      if (bus.done || !bus.req[m_owner] || m_held == HOLD_MAX) begin
        m_to    = !bus.done && bus.req[m_owner];
        m_last  = m_owner;
        m_ptr   = (m_owner + 1) % N_REQ;
        m_owner = -1;
        m_rel   = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      m_to  = 1'b0;
      m_rel = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        if (m_owner < 0 && bus.req[(m_ptr + k) % N_REQ]) begin
          m_owner = (m_ptr + k) % N_REQ;
          m_held  = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? N_REQ'(1 << m_owner) : '0;
    check("model_gnt", bus.gnt, exp_gnt);
    check("model_busy", bus.busy, m_owner >= 0);
    check("model_timeout", bus.timeout, m_to);
    check("any_req", bus.any_req, |bus.req);
    check("gnt_onehot0", $onehot0(bus.gnt), 1);
    check("busy_eq_or_gnt", bus.busy, |bus.gnt);
    if (m_owner >= 0) check("model_gnt_id", bus.gnt_id, m_owner);
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req[i] && m_owner != i && !(m_rel && m_last == i)) age[i]++;
      else age[i] = 0;
      if (age[i] > 0) check("wait_bound", age[i] <= BOUND, 1);
    end
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N_REQ-1:0] r;
    for (int i = 0; i < N_REQ; i++) age[i] = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    tick(2);
    check("rst_gnt", bus.gnt, 4'b0000);
    check("rst_busy", bus.busy, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_gnt_id", bus.gnt_id, 0);

    // Single requester, released by done.
    rst_n   = 1'b1;
    bus.req = 4'b0001;
    tick(1);
    check("first_gnt", bus.gnt, 4'b0001);
    check("first_gnt_id", bus.gnt_id, 0);
    check("first_busy", bus.busy, 1);
    tick(2);
    bus.done = 1'b1;
    tick(1);
    check("done_release_gnt", bus.gnt, 4'b0000);
    check("done_release_to", bus.timeout, 0);
    bus.done = 1'b0;
    bus.req  = '0;
    tick(1);
    check("idle_gnt", bus.gnt, 4'b0000);

    // All requesting: strict rotation with one empty cycle between grants.
    rst_n = 1'b0;
    tick(1);
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick(1);
      check("rot_gnt", bus.gnt, onehot(ID_W'(order[n])));
      tick(1);
      bus.done = 1'b1;
      tick(1);
      check("rot_gap", bus.gnt, 4'b0000);
      bus.done = 1'b0;
    end
    bus.req = '0;
    tick(1);

    // Hold limit: 8 cycles of grant, one timeout cycle, then re-grant.
    bus.req = 4'b0100;
    tick(1);
    for (int n = 0; n < HOLD_MAX; n++) begin
      check("hold_gnt", bus.gnt, 4'b0100);
      check("hold_no_to", bus.timeout, 0);
      tick(1);
    end
    check("forced_gnt", bus.gnt, 4'b0000);
    check("forced_to", bus.timeout, 1);
    tick(1);
    check("regrant_gnt", bus.gnt, 4'b0100);
    check("regrant_to", bus.timeout, 0);

    // done on the limit cycle counts as a normal release.
    tick(HOLD_MAX - 1);
    bus.done = 1'b1;
    tick(1);
    check("done_at_limit_gnt", bus.gnt, 4'b0000);
    check("done_at_limit_to", bus.timeout, 0);
    bus.done = 1'b0;
    tick(1);
    check("regrant2_gnt", bus.gnt, 4'b0100);

    // Owner drops its request mid-grant.
    tick(1);
    bus.req = '0;
    tick(1);
    check("drop_gnt", bus.gnt, 4'b0000);
    check("drop_to", bus.timeout, 0);
    tick(1);

    // done while idle is ignored.
    bus.done = 1'b1;
    tick(1);
    check("idle_done_busy", bus.busy, 0);
    bus.done = 1'b0;

    // A request withdrawn before its turn is skipped; others do not disturb the owner.
    bus.req = 4'b0001;
    tick(1);
    check("wrap_gnt", bus.gnt, 4'b0001);
    bus.req = 4'b0011;
    tick(1);
    bus.req  = 4'b0101;
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    tick(1);
    check("skip_dropped_gnt", bus.gnt, 4'b0100);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    bus.req  = '0;
    tick(1);

    // Reset during a grant, then the first grant restarts from index 0.
    bus.req = 4'b1010;
    tick(1);
    check("pre_rst_gnt", bus.gnt, 4'b1000);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_gnt", bus.gnt, 4'b0000);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_to", bus.timeout, 0);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_gnt", bus.gnt, 4'b0010);
    check("post_rst_gnt_id", bus.gnt_id, 1);

    // Random soak against the model.
    for (int n = 0; n < 10000; n++) begin
      r = bus.req;
      for (int b = 0; b < N_REQ; b++)
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      bus.req  = r;
      bus.done = ($urandom_range(7) == 0);
      tick(1);
    end
    bus.req  = '0;
    bus.done = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum number of cycles one grant may be held before a forced release; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 req  input  4  request lines, one per requester; level-sensitive.
REQ-005 done  input  1  release strobe from the current owner; 1-cycle pulse.
REQ-006 gnt  output  4  one-hot grant, registered; all zeros when no owner.
REQ-007 gnt_id  output  2  binary index of the current owner, registered; valid only while busy=1.
REQ-008 busy  output  1  registered; high while any gnt bit is high.
REQ-009 any_req  output  1  combinational OR of req[3:0]; this is the only unregistered output.
REQ-010 timeout  output  1  registered 1-cycle pulse on a forced release.

Function
REQ-011 The block SHALL implement a 3-state FSM: IDLE, GRANT, RELEASE.
REQ-012 IDLE: if any_req=1, the next state SHALL be GRANT, with gnt/gnt_id set to the winner on that edge (1-cycle request-to-grant latency); otherwise the FSM SHALL stay in IDLE.
REQ-013 The winner SHALL be the first asserted req index at or after ptr, searching upward with wrap from 3 to 0.
REQ-014 ptr SHALL reset to 0 and SHALL be set to (owner+1) mod 4 on every release.
REQ-015 GRANT: hold_cnt SHALL load 1 on grant entry and increment by 1 each cycle spent in GRANT; the counter is 8 bits and never wraps.
REQ-016 GRANT exits to RELEASE on the first of these: done=1; req[owner]=0; hold_cnt=HOLD_MAX.
REQ-017 On the edge entering RELEASE, gnt SHALL become 0000 and busy SHALL become 0.
REQ-018 timeout SHALL pulse high for exactly the RELEASE cycle when the exit was caused only by hold_cnt=HOLD_MAX.
REQ-019 If done=1 or req[owner]=0 coincides with hold_cnt=HOLD_MAX, the release SHALL count as normal and timeout SHALL stay 0.
REQ-020 RELEASE SHALL last exactly one cycle.
REQ-021 From RELEASE, the FSM SHALL arbitrate using the updated ptr: if any_req=1, go to GRANT with the new winner; otherwise go to IDLE. A request therefore waits at most 3 x (HOLD_MAX+1) cycles after being asserted.
REQ-022 Changes on req lines other than the owner's SHALL NOT affect a grant in progress.
REQ-023 done while busy=0 SHALL be ignored.
REQ-024 gnt SHALL never have more than one bit set in any cycle.
REQ-025 A requester that drops req before its grant is issued SHALL NOT be granted.

Reset
REQ-026 While rst_n=0 at a clock edge: state=IDLE, gnt=0000, gnt_id=00, busy=0, timeout=0, ptr=0, hold_cnt=0.
REQ-027 Reset asserted during GRANT SHALL drop gnt at that same edge, with no RELEASE cycle and no timeout pulse.
REQ-028 The first grant after reset deassertion SHALL follow REQ-012 with ptr=0.

Structure
REQ-029 A shared package rr_arb_pkg SHALL hold the state enum (IDLE/GRANT/RELEASE), N_REQ=4, ID_W=2, and CNT_W=8.
REQ-030 The rotating priority search SHALL be one combinational sub-module, rr_pick (inputs req, ptr; outputs valid, idx), instantiated once.
REQ-031 No latches and no gated clocks; the only combinational output is any_req.

Verification
REQ-032 Reset, then req=0001 at cycle 0 -> gnt=0001, gnt_id=0, busy=1 at cycle 1; done at cycle 3 -> gnt=0000 at cycle 4, timeout=0.
REQ-033 req=1111 held, done pulsed 2 cycles after each grant -> grant order 0,1,2,3,0, with exactly one zero-gnt cycle between grants.
REQ-034 HOLD_MAX=8, req=0100 held, no done -> gnt=0100 for 8 cycles, then gnt=0000 with timeout=1 for 1 cycle, then re-grant to 2.
REQ-035 done=1 on the same cycle hold_cnt=HOLD_MAX -> release with timeout=0; owner drops req mid-grant -> release on the next edge.
REQ-036 rst_n=0 during GRANT with req=1010 -> gnt=0000 at that edge; after rst_n=1 -> first grant goes to index 1 (ptr=0).
REQ-037 Random req/done, 10k cycles: assert gnt is one-hot-or-zero, busy equals |gnt, any_req equals |req, and every request is served within 3 x (HOLD_MAX+1) cycles.
